// File: rtl/bist_response_analyzer.sv
// Purpose : BIST receive end; skips warm-up beats, compacts circuit-under-test
//           responses into a MISR signature and compares it against a golden value.
// Latency : SIGNATURE/COUNT update the edge after each accepted beat; DONE/PASS
//           become valid the cycle after the last compacted beat.
// Backpressure: none. Every RESP_VALID beat is consumed in WARMUP/COMPACT, and
//           beats arriving in IDLE/DONE are dropped.
//
// Ports:
//   CK          clock, rising edge
//   RST         synchronous active-high reset
//   START       one-cycle run request (honoured in IDLE or DONE only)
//   GOLDEN      expected signature, captured with an accepted START
//   RESP_VALID  RESP holds a valid response beat
//   RESP        response beat, LSB-aligned circuit primary outputs
//   BUSY        run in progress (WARMUP or COMPACT)
//   DONE        run finished; level held until START or RST
//   PASS        final signature matched GOLDEN (only ever set while DONE)
//   SIGNATURE   live MISR contents
//   COUNT       beats compacted in the current run

module bist_response_analyzer #(
  parameter int                 WIDTH        = 4,
  parameter int                 SIG_W        = 16,
  parameter logic [SIG_W-1:0]   POLY         = 16'h1021,
  parameter int                 NUM_PATTERNS = 64,
  parameter int                 WARMUP       = 2,
  localparam int                CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [SIG_W-1:0]      GOLDEN,
  input  logic                  RESP_VALID,
  input  logic [WIDTH-1:0]      RESP,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [SIG_W-1:0]      SIGNATURE,
  output logic [CNT_W-1:0]      COUNT
);

  // A zero warm-up never reaches the WARMUP state, but the counter still
  // needs at least one bit to stay a legal vector.
  localparam int                WARM_W    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_COMPACT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WARM_W-1:0]   warm_q,  warm_d;
  logic [SIG_W-1:0]    sig_q,   sig_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [SIG_W-1:0]    gold_q,  gold_d;
  logic                pass_q,  pass_d;

  logic [SIG_W-1:0]    resp_ext;
  logic [SIG_W-1:0]    misr_nxt;

  // One MISR step: shift left, fold the outgoing MSB back through the
  // polynomial taps, then inject the response beat.
  always_comb begin
    resp_ext = SIG_W'(RESP);
    misr_nxt = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    gold_d  = gold_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A beat arriving together with START is not consumed; the run
        // starts taking beats from the following cycle.
        if (START) begin
          sig_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          gold_d  = GOLDEN;
          warm_d  = WARM_INIT;
          state_d = (WARMUP == 0) ? S_COMPACT : S_WARMUP;
        end
      end

      S_WARMUP: begin
        if (RESP_VALID) begin
          warm_d = warm_q - 1'b1;
          if (warm_q == WARM_W'(1)) begin
            state_d = S_COMPACT;
          end
        end
      end

      S_COMPACT: begin
        if (RESP_VALID) begin
          sig_d = misr_nxt;
          cnt_d = cnt_q + 1'b1;
          // Compare against the signature being written this edge so PASS
          // lands together with DONE.
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            pass_d  = (misr_nxt == gold_q);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      warm_q  <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      gold_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      gold_q  <= gold_d;
      pass_q  <= pass_d;
    end
  end

  // All outputs come straight from registers.
  assign BUSY      = (state_q == S_WARMUP) || (state_q == S_COMPACT);
  assign DONE      = (state_q == S_DONE);
  assign PASS      = pass_q;
  assign SIGNATURE = sig_q;
  assign COUNT     = cnt_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: four instances with different run lengths
// and warm-up depths share one stimulus stream and are compared every cycle
// against a beat-level reference model, plus directed known-answer checks.

module tb_bist_response_analyzer;

  localparam int N_INST = 4;
  localparam int M_IDLE = 0, M_WARM = 1, M_COMP = 2, M_DONE = 3;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] GOLDEN = '0;
  logic        RESP_VALID = 1'b0;
  logic [3:0]  RESP = '0;

  always #5 CK = ~CK;

  logic [15:0] sig_a  [N_INST];
  logic [7:0]  cnt_a  [N_INST];
  logic        busy_a [N_INST];
  logic        done_a [N_INST];
  logic        pass_a [N_INST];

  function automatic int np_of(input int i);
    case (i)
      0:       return 3;
      1:       return 17;
      2:       return 3;
      default: return 64;
    endcase
  endfunction

  function automatic int wu_of(input int i);
    return (i >= 2) ? 2 : 0;
  endfunction

  genvar g;
  generate
    for (g = 0; g < N_INST; g++) begin : g_dut
      localparam int NP = np_of(g);
      localparam int CW = $clog2(NP + 1);
      logic [CW-1:0] cnt;
      logic [15:0]   sig;
      logic          busy, done, pass;

      bist_response_analyzer #(
        .WIDTH        (4),
        .SIG_W        (16),
        .POLY         (16'h1021),
        .NUM_PATTERNS (NP),
        .WARMUP       (wu_of(g))
      ) u_dut (
        .CK         (CK),
        .RST        (RST),
        .START      (START),
        .GOLDEN     (GOLDEN),
        .RESP_VALID (RESP_VALID),
        .RESP       (RESP),
        .BUSY       (busy),
        .DONE       (done),
        .PASS       (pass),
        .SIGNATURE  (sig),
        .COUNT      (cnt)
      );

      assign sig_a[g]  = sig;
      assign cnt_a[g]  = 8'(cnt);
      assign busy_a[g] = busy;
      assign done_a[g] = done;
      assign pass_a[g] = pass;
    end
  endgenerate

  // ---------------- reference model ----------------
  // Polynomial division step over GF(2): multiply by x, reduce by POLY if the
  // x^16 term appears, then add the response word.
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] r);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {12'h000, r};
  endfunction

  int          m_mode [N_INST];
  int          m_warm [N_INST];
  int          m_cnt  [N_INST];
  logic [15:0] m_sig  [N_INST];
  logic [15:0] m_gold [N_INST];
  logic        m_pass [N_INST];

  always @(posedge CK) begin
    for (int i = 0; i < N_INST; i++) begin
      if (RST) begin
        m_mode[i] <= M_IDLE;
        m_warm[i] <= 0;
        m_cnt[i]  <= 0;
        m_sig[i]  <= '0;
        m_gold[i] <= '0;
        m_pass[i] <= 1'b0;
      end else if (m_mode[i] == M_IDLE || m_mode[i] == M_DONE) begin
        if (START) begin
          m_sig[i]  <= '0;
          m_cnt[i]  <= 0;
          m_pass[i] <= 1'b0;
          m_gold[i] <= GOLDEN;
          m_warm[i] <= wu_of(i);
          m_mode[i] <= (wu_of(i) == 0) ? M_COMP : M_WARM;
        end
      end else if (m_mode[i] == M_WARM) begin
        if (RESP_VALID) begin
          m_warm[i] <= m_warm[i] - 1;
          if (m_warm[i] - 1 == 0) m_mode[i] <= M_COMP;
        end
      end else begin
        if (RESP_VALID) begin
          m_sig[i] <= misr(m_sig[i], RESP);
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == np_of(i)) begin
            m_mode[i] <= M_DONE;
            m_pass[i] <= (misr(m_sig[i], RESP) == m_gold[i]);
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N_INST; i++) begin
      chk($sformatf("u%0d sig", i),  32'(sig_a[i]),  32'(m_sig[i]));
      chk($sformatf("u%0d cnt", i),  32'(cnt_a[i]),  32'(m_cnt[i]));
      chk($sformatf("u%0d busy", i), 32'(busy_a[i]),
          32'(m_mode[i] == M_WARM || m_mode[i] == M_COMP));
      chk($sformatf("u%0d done", i), 32'(done_a[i]), 32'(m_mode[i] == M_DONE));
      chk($sformatf("u%0d pass", i), 32'(pass_a[i]), 32'(m_pass[i]));
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge CK);
    #1;
    compare_all();
  endtask

  task automatic beat(input logic [3:0] r);
    RESP_VALID = 1'b1;
    RESP       = r;
    step();
    RESP_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] gold);
    START  = 1'b1;
    GOLDEN = gold;
    step();
    START  = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    do_reset();
    for (int i = 0; i < N_INST; i++) begin
      chk("rst sig", 32'(sig_a[i]), 32'h0);
      chk("rst cnt", 32'(cnt_a[i]), 32'h0);
      chk("rst done", 32'(done_a[i]), 32'h0);
      chk("rst busy", 32'(busy_a[i]), 32'h0);
    end

    // Basic run on the 3-beat, no-warm-up instance
    do_start(16'h0003);
    chk("basic busy", 32'(busy_a[0]), 32'h1);
    beat(4'h1); chk("basic sig1", 32'(sig_a[0]), 32'h0001);
    beat(4'h2); chk("basic sig2", 32'(sig_a[0]), 32'h0000);
    beat(4'h3); chk("basic sig3", 32'(sig_a[0]), 32'h0003);
    chk("basic done", 32'(done_a[0]), 32'h1);
    chk("basic pass", 32'(pass_a[0]), 32'h1);
    chk("basic cnt",  32'(cnt_a[0]),  32'h3);
    chk("basic busy0", 32'(busy_a[0]), 32'h0);

    // Restart from DONE with a golden value that cannot match
    do_start(16'h1234);
    chk("rs done", 32'(done_a[0]), 32'h0);
    chk("rs sig",  32'(sig_a[0]),  32'h0);
    chk("rs cnt",  32'(cnt_a[0]),  32'h0);
    beat(4'h1); beat(4'h2); beat(4'h3);
    chk("rs done2", 32'(done_a[0]), 32'h1);
    chk("rs pass0", 32'(pass_a[0]), 32'h0);
    do_start(16'h0003);
    beat(4'h1); beat(4'h2); beat(4'h3);
    chk("rs pass1", 32'(pass_a[0]), 32'h1);

    // Feedback tap on the 17-beat instance
    do_reset();
    do_start(16'h1020);
    beat(4'h1);
    for (int k = 0; k < 15; k++) beat(4'h0);
    chk("fb sig16", 32'(sig_a[1]), 32'h8000);
    beat(4'h0);
    chk("fb sig17", 32'(sig_a[1]), 32'h1021);
    chk("fb done",  32'(done_a[1]), 32'h1);
    chk("fb pass",  32'(pass_a[1]), 32'h0);
    chk("fb cnt",   32'(cnt_a[1]),  32'd17);

    // Warm-up skip on the WARMUP=2 instance
    do_reset();
    do_start(16'h0003);
    beat(4'hF);
    chk("wu sig1", 32'(sig_a[2]), 32'h0);
    chk("wu cnt1", 32'(cnt_a[2]), 32'h0);
    beat(4'hF);
    chk("wu sig2", 32'(sig_a[2]), 32'h0);
    chk("wu cnt2", 32'(cnt_a[2]), 32'h0);
    beat(4'h1); beat(4'h2); beat(4'h3);
    chk("wu sig", 32'(sig_a[2]), 32'h0003);
    chk("wu pass", 32'(pass_a[2]), 32'h1);

    // Gaps and ignored inputs
    do_reset();
    RESP_VALID = 1'b1; RESP = 4'h7;
    step(); step(); step();
    chk("idle sig", 32'(sig_a[0]), 32'h0);
    chk("idle cnt", 32'(cnt_a[0]), 32'h0);
    RESP = 4'h5;
    do_start(16'h0003);           // beat with START is not consumed
    RESP_VALID = 1'b0;
    chk("st+v cnt", 32'(cnt_a[0]), 32'h0);
    chk("st+v sig", 32'(sig_a[0]), 32'h0);
    for (int b = 1; b <= 3; b++) begin
      beat(4'(b));
      for (int k = 0; k < 4; k++) begin
        if (b == 2 && k == 1) do_start(16'hFFFF);  // ignored while busy
        else step();
      end
    end
    chk("gap sig",  32'(sig_a[0]),  32'h0003);
    chk("gap pass", 32'(pass_a[0]), 32'h1);

    // Reset mid-run
    do_reset();
    do_start(16'h0003);
    beat(4'h1); beat(4'h2);
    do_reset();
    for (int i = 0; i < N_INST; i++) begin
      chk("mid sig",  32'(sig_a[i]),  32'h0);
      chk("mid cnt",  32'(cnt_a[i]),  32'h0);
      chk("mid busy", 32'(busy_a[i]), 32'h0);
      chk("mid done", 32'(done_a[i]), 32'h0);
      chk("mid pass", 32'(pass_a[i]), 32'h0);
    end
    do_start(16'h0003);
    beat(4'h1); beat(4'h2); beat(4'h3);
    chk("mid pass1", 32'(pass_a[0]), 32'h1);

    // Randomised traffic, checked every cycle against the model
    for (int c = 0; c < 4000; c++) begin
      RST        = ($urandom_range(0, 299) == 0);
      START      = ($urandom_range(0, 24) == 0);
      GOLDEN     = 16'($urandom);
      RESP_VALID = ($urandom_range(0, 9) < 7);
      RESP       = 4'($urandom);
      step();
    end
    RST = 1'b0; START = 1'b0; RESP_VALID = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bist_response_analyzer.md
Name: bist_response_analyzer

Overview:
- Receive end of the on-chip test loop for the ISCAS89 benchmark circuits: consumes the per-cycle primary-output response of the circuit under test and compacts it into a signature with a MISR (multiple-input signature register).
- The pattern generator drives the circuit under test. This block reads the results, skips the flop-initialisation cycles, counts compacted patterns, and compares the final signature against a golden value latched at START.

Parameters:
- WIDTH, 4, response bits per beat (circuit primary outputs, LSB-aligned); 1 <= WIDTH <= SIG_W.
- SIG_W, 16, signature width.
- POLY, 16'h1021, MISR feedback polynomial; bit i set means tap XOR into bit i; SIG_W bits wide.
- NUM_PATTERNS, 64, number of beats compacted per run; >= 1.
- WARMUP, 2, number of leading valid beats discarded (flop initialisation); >= 0.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- START  input  1  one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- GOLDEN  input  SIG_W  expected signature; sampled on the cycle START is accepted.
- RESP_VALID  input  1  RESP carries a valid response beat this cycle.
- RESP  input  WIDTH  circuit-under-test response beat.
- BUSY  output  1  high in WARMUP and COMPACT.
- DONE  output  1  high in DONE state (level, held).
- PASS  output  1  final signature == latched GOLDEN; meaningful only while DONE=1, else 0.
- SIGNATURE  output  SIG_W  current MISR contents (live, registered).
- COUNT  output  clog2(NUM_PATTERNS+1)  number of beats compacted so far in the current run.

Behaviour:
- Reset: RST=1 at a CK edge forces state IDLE and clears BUSY, DONE, PASS, SIGNATURE, COUNT, the warm-up counter and the golden register to 0. Reset overrides START and RESP_VALID in the same cycle. Reset mid-run aborts the run with no partial result.
- States: IDLE, WARMUP, COMPACT, DONE.
- IDLE or DONE with START=1:
  - clear SIGNATURE and COUNT, clear PASS, latch GOLDEN;
  - load the warm-up counter with WARMUP;
  - next state is WARMUP, or COMPACT directly if WARMUP=0.
- WARMUP:
  - each RESP_VALID=1 cycle decrements the warm-up counter; RESP is ignored, SIGNATURE is unchanged.
  - When the beat that brings the counter to 0 is consumed, next state is COMPACT.
  - The first COMPACT beat is the cycle after that.
- COMPACT, each RESP_VALID=1 cycle:
  - SIGNATURE <= {SIGNATURE[SIG_W-2:0],1'b0} ^ (SIGNATURE[SIG_W-1] ? POLY : 0) ^ zero-extend(RESP).
  - COUNT <= COUNT+1.
  - RESP_VALID=0 cycles hold all state; gaps are allowed anywhere.
- End of run: on the COMPACT beat where COUNT == NUM_PATTERNS-1, next state is DONE and PASS <= (next SIGNATURE == latched GOLDEN), registered in the same edge. DONE and PASS are therefore valid the cycle after the last beat, and COUNT == NUM_PATTERNS.
- DONE: DONE=1, BUSY=0. SIGNATURE, COUNT and PASS are held until START or RST.
- RESP_VALID in IDLE or DONE is ignored.
- START while BUSY=1 is ignored, including GOLDEN sampling.
- START and RESP_VALID in the same cycle in IDLE/DONE: the beat is not consumed; the run begins next cycle.
- No combinational path from inputs to outputs.

Test Plan:
- Basic run (NUM_PATTERNS=3, WARMUP=0, GOLDEN=16'h0003): START, then RESP=1,2,3 with valid on 3 consecutive cycles -> SIGNATURE 0001, 0000, 0003; DONE=1 and PASS=1 one cycle after the 3rd beat; COUNT=3.
- Feedback tap (NUM_PATTERNS=17, WARMUP=0): RESP=1 followed by 16 beats of RESP=0 -> SIGNATURE=16'h8000 after beat 16, 16'h1021 after beat 17. GOLDEN=16'h1020 gives PASS=0, DONE=1.
- Warm-up skip (WARMUP=2, NUM_PATTERNS=3): beats RESP=F,F,1,2,3 -> first two beats leave SIGNATURE=0 and COUNT=0; final SIGNATURE=16'h0003.
- Gaps/ignores: same as basic run with RESP_VALID low for 4 cycles between beats, plus a START pulse mid-run and RESP_VALID=1 while IDLE -> identical final SIGNATURE 16'h0003 and PASS=1.
- Reset mid-run: RST=1 after beat 2 -> next cycle all outputs 0, state IDLE. A new START and full run completes normally with PASS=1.
- Restart from DONE: START while DONE=1 with new GOLDEN -> DONE falls next cycle, SIGNATURE/COUNT cleared, new GOLDEN used for the second run's PASS.
